// File: rtl/cnn_pkg.sv
//------------------------------------------------------------------------------
// Module   : cnn_pkg
// Purpose  : Shared definitions for the convolution-layer memory subsystem:
//            word/address widths, memory-client index assignments and the
//            arbiter state encoding.
// Contents : DATA_SZ, ADDR_SZ, NREQ_DEF, REQ_LOAD/REQ_PREV/REQ_WRITE,
//            arb_state_t
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cnn_pkg;

  localparam int DATA_SZ  = 16;
  localparam int ADDR_SZ  = 16;
  localparam int NREQ_DEF = 3;

  // Memory-client slots on the shared feature/weight RAM port
  localparam int REQ_LOAD  = 0;  // image/filter loader
  localparam int REQ_PREV  = 1;  // previous-partial-sum loader
  localparam int REQ_WRITE = 2;  // result writer

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
//------------------------------------------------------------------------------
// Module   : rr_pick
// Purpose  : Combinational round-robin search. Scans the request vector
//            starting one slot after the last winner and wrapping, and
//            returns the first requester found.
// Ports    : i_req   - request vector
//            i_last  - index of the previous winner
//            o_pick  - one-hot winner (zero when nothing requests)
//            o_idx   - binary index of the winner
//            o_found - a winner exists
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int NREQ = 3,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDXW-1:0] i_last,
  output logic [NREQ-1:0] o_pick,
  output logic [IDXW-1:0] o_idx,
  output logic            o_found
);

  // Offsets 1..NREQ from the last winner; the last winner itself is visited
  // at offset NREQ, so it only wins when nobody else is asking.
  always_comb begin : p_search
    int w_cand;
    w_cand  = 0;
    o_pick  = '0;
    o_idx   = '0;
    o_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = (int'(i_last) + k) % NREQ;
      if (!o_found && i_req[w_cand]) begin
        o_found        = 1'b1;
        o_pick[w_cand] = 1'b1;
        o_idx          = IDXW'(w_cand);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : mem_port_arbiter
// Purpose  : Shares the single-port feature/weight RAM between the
//            convolution layer's memory clients. Round-robin arbitration
//            with an optional lock for multi-word bursts; one word moves per
//            granted cycle.
// Ports    : clk, reset       - clock, asynchronous active-high reset
//            req/lock/we      - per-requester request, burst lock, write flag
//            addr/wdata       - flattened per-requester address / write data
//            gnt              - one-hot registered grant
//            rvalid/rdata     - one-hot read-return tag, shared read data
//            mem_en/mem_we    - RAM strobe / write enable
//            mem_addr/wdata   - RAM address / write data
//            mem_rdata        - RAM read data (1-cycle latency)
//            busy             - a grant is held
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
  parameter int NREQ    = cnn_pkg::NREQ_DEF,
  parameter int DATA_SZ = cnn_pkg::DATA_SZ,
  parameter int ADDR_SZ = cnn_pkg::ADDR_SZ
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         lock,
  input  logic [NREQ-1:0]         we,
  input  logic [NREQ*ADDR_SZ-1:0] addr,
  input  logic [NREQ*DATA_SZ-1:0] wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         rvalid,
  output logic [DATA_SZ-1:0]      rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_SZ-1:0]      mem_addr,
  output logic [DATA_SZ-1:0]      mem_wdata,
  input  logic [DATA_SZ-1:0]      mem_rdata,
  output logic                    busy
);

  import cnn_pkg::*;

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t       r_state;
  logic [IDXW-1:0]  r_owner;
  logic [IDXW-1:0]  r_last;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_rvalid;
  logic             r_busy;

  logic [NREQ-1:0]  w_pick;
  logic [IDXW-1:0]  w_pick_idx;
  logic             w_found;
  logic             w_own_req;
  logic             w_own_lock;
  logic             w_own_we;
  logic             w_owned;
  logic             w_release;
  logic             w_xfer;

  assign w_owned    = (r_state == ST_OWNED);
  assign w_own_req  = req[r_owner];
  assign w_own_lock = lock[r_owner];
  assign w_own_we   = we[r_owner];

  // Lock alone never holds the port: a dropped req releases even under lock.
  assign w_release  = !w_owned || !w_own_req || !w_own_lock;

  // A granted requester only moves a word while it still asserts req.
  assign w_xfer     = w_owned && w_own_req;

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_pick (
    .i_req   (req),
    .i_last  (r_last),
    .o_pick  (w_pick),
    .o_idx   (w_pick_idx),
    .o_found (w_found)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_last   <= IDXW'(NREQ - 1);
      r_gnt    <= '0;
      r_busy   <= 1'b0;
      r_rvalid <= '0;
    end else begin
      // Read-return tag follows the transfer by one cycle regardless of
      // where the grant moves next.
      r_rvalid <= (w_xfer && !w_own_we) ? r_gnt : '0;

      if (w_release) begin
        if (w_found) begin
          r_state <= ST_OWNED;
          r_owner <= w_pick_idx;
          r_last  <= w_pick_idx;
          r_gnt   <= w_pick;
          r_busy  <= 1'b1;
        end else begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      end
    end
  end

  assign gnt       = r_gnt;
  assign rvalid    = r_rvalid;
  assign busy      = r_busy;

  assign mem_en    = w_xfer;
  assign mem_we    = w_xfer && w_own_we;
  assign mem_addr  = w_xfer ? addr[r_owner*ADDR_SZ +: ADDR_SZ]  : '0;
  assign mem_wdata = w_xfer ? wdata[r_owner*DATA_SZ +: DATA_SZ] : '0;

  // Data is a pass-through of the RAM; zeroed when no return is tagged.
  assign rdata     = (|r_rvalid) ? mem_rdata : '0;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(gnt));

  a_en_needs_gnt: assert property (@(posedge clk) disable iff (reset)
    mem_en |-> (gnt != '0));

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter with a behavioural RAM
//            and a read-return scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 16;
  localparam int AW   = 16;

  typedef struct {
    logic [NREQ-1:0] vec;
    logic [DW-1:0]   data;
  } exp_t;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      lock;
  logic [NREQ-1:0]      we;
  logic [NREQ*AW-1:0]   addr;
  logic [NREQ*DW-1:0]   wdata;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      rvalid;
  logic [DW-1:0]        rdata;
  logic                 mem_en;
  logic                 mem_we;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_wdata;
  logic [DW-1:0]        mem_rdata;
  logic                 busy;

  logic [DW-1:0]        ram [0:65535];
  exp_t                 sb [$];
  int                   n_chk;
  int                   n_err;
  logic [NREQ-1:0]      t2_gnt [4];
  logic [AW-1:0]        t2_addr [4];

  mem_port_arbiter #(
    .NREQ    (NREQ),
    .DATA_SZ (DW),
    .ADDR_SZ (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .lock      (lock),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM, one cycle read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return (a * 16'd7) ^ 16'hC3A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic r, input logic l, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]            = r;
    lock[i]           = l;
    we[i]             = w;
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Scoreboard consumer: every tagged read return must match the oldest
  // outstanding expectation.
  always @(negedge clk) begin
    if (rvalid != '0) begin
      if (sb.size() == 0) begin
        chk("rv_unexpected", 32'(rvalid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rvalid", 32'(rvalid), 32'(e.vec));
        chk("rdata",  32'(rdata),  32'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < 65536; i++) ram[i] = pat(16'(i));
    ram[16'h0040] = 16'h1234;
    t2_gnt  = '{3'b001, 3'b010, 3'b100, 3'b001};
    t2_addr = '{16'h0200, 16'h0300, 16'h0400, 16'h0200};

    reset = 1'b1;
    req   = '0;
    lock  = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;

    // Reset state
    @(negedge clk);
    chk("rst_gnt",    32'(gnt),       32'd0);
    chk("rst_rvalid", 32'(rvalid),    32'd0);
    chk("rst_busy",   32'(busy),      32'd0);
    chk("rst_en",     32'(mem_en),    32'd0);
    chk("rst_we",     32'(mem_we),    32'd0);
    chk("rst_addr",   32'(mem_addr),  32'd0);
    chk("rst_wdata",  32'(mem_wdata), 32'd0);
    chk("rst_rdata",  32'(rdata),     32'd0);
    step();
    reset = 1'b0;

    // T1: single reader
    set_req(0, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000);
    sb.push_back('{3'b001, 16'h1234});
    step();
    @(negedge clk);
    chk("t1_gnt",  32'(gnt),      32'h1);
    chk("t1_en",   32'(mem_en),   32'h1);
    chk("t1_addr", 32'(mem_addr), 32'h40);
    chk("t1_we",   32'(mem_we),   32'h0);
    chk("t1_busy", 32'(busy),     32'h1);
    step();
    req[0] = 1'b0;
    @(negedge clk);
    chk("t1_no_en", 32'(mem_en), 32'h0);
    step();
    @(negedge clk);
    chk("t1_idle_gnt",  32'(gnt),  32'h0);
    chk("t1_idle_busy", 32'(busy), 32'h0);

    // T2: three continuous unlocked requesters rotate
    reset_pulse();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 1'b0, 16'h0200 + 16'(i) * 16'h0100, 16'h0);
    for (int k = 0; k < 4; k++) sb.push_back('{t2_gnt[k], pat(t2_addr[k])});
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      chk("t2_gnt",  32'(gnt),      32'(t2_gnt[k]));
      chk("t2_en",   32'(mem_en),   32'h1);
      chk("t2_addr", 32'(mem_addr), 32'(t2_addr[k]));
    end
    step();
    req = '0;
    @(negedge clk);
    chk("t2_no_en", 32'(mem_en), 32'h0);
    step();
    @(negedge clk);
    chk("t2_idle", 32'(gnt), 32'h0);

    // T3: locked 25-word burst from requester 0 while requester 2 waits
    reset_pulse();
    set_req(0, 1'b1, 1'b1, 1'b0, 16'h0100, 16'h0);
    set_req(2, 1'b1, 1'b0, 1'b1, 16'h0500, 16'hBEEF);
    for (int k = 0; k < 25; k++) sb.push_back('{3'b001, pat(16'h0100 + 16'(k))});
    for (int k = 0; k < 25; k++) begin
      step();
      if (k > 0) addr[0 +: AW] = 16'h0100 + 16'(k);
      @(negedge clk);
      chk("t3_gnt",  32'(gnt),      32'h1);
      chk("t3_en",   32'(mem_en),   32'h1);
      chk("t3_addr", 32'(mem_addr), 32'h100 + 32'(k));
    end
    step();
    req[0]  = 1'b0;
    lock[0] = 1'b0;
    @(negedge clk);
    chk("t3_tail_gnt", 32'(gnt),    32'h1);
    chk("t3_tail_en",  32'(mem_en), 32'h0);
    step();
    @(negedge clk);
    chk("t3_w_gnt",   32'(gnt),       32'h4);
    chk("t3_w_we",    32'(mem_we),    32'h1);
    chk("t3_w_addr",  32'(mem_addr),  32'h500);
    chk("t3_w_wdata", 32'(mem_wdata), 32'hBEEF);
    step();
    req[2] = 1'b0;
    step();
    @(negedge clk);
    chk("t3_idle", 32'(gnt), 32'h0);

    // T4: write then read back through another requester
    set_req(2, 1'b1, 1'b0, 1'b1, 16'h0400, 16'h7FFF);
    step();
    @(negedge clk);
    chk("t4_w_gnt",   32'(gnt),       32'h4);
    chk("t4_w_we",    32'(mem_we),    32'h1);
    chk("t4_w_addr",  32'(mem_addr),  32'h400);
    chk("t4_w_wdata", 32'(mem_wdata), 32'h7FFF);
    step();
    req[2] = 1'b0;
    set_req(1, 1'b1, 1'b0, 1'b0, 16'h0400, 16'h0);
    sb.push_back('{3'b010, 16'h7FFF});
    step();
    @(negedge clk);
    chk("t4_r_gnt",  32'(gnt),      32'h2);
    chk("t4_r_en",   32'(mem_en),   32'h1);
    chk("t4_r_we",   32'(mem_we),   32'h0);
    step();
    req[1] = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("t4_idle", 32'(gnt), 32'h0);

    // T5: asynchronous reset in the middle of a locked read burst
    set_req(0, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0);
    sb.push_back('{3'b001, pat(16'h0010)});
    step();
    step();
    @(negedge clk);
    chk("t5_pre_gnt", 32'(gnt),    32'h1);
    chk("t5_pre_en",  32'(mem_en), 32'h1);
    chk("t5_pre_rv",  32'(rvalid), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rst_gnt",  32'(gnt),    32'h0);
    chk("t5_rst_rv",   32'(rvalid), 32'h0);
    chk("t5_rst_en",   32'(mem_en), 32'h0);
    chk("t5_rst_busy", 32'(busy),   32'h0);
    set_req(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_req(2, 1'b1, 1'b0, 1'b1, 16'h0600, 16'h1111);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_hold_gnt", 32'(gnt), 32'h0);
    step();
    @(negedge clk);
    chk("t5_gnt",  32'(gnt),    32'h4);
    chk("t5_we",   32'(mem_we), 32'h1);
    step();
    req[2] = 1'b0;
    step();
    @(negedge clk);
    chk("t5_idle", 32'(gnt), 32'h0);

    // T6: owner drops req while still holding lock
    set_req(1, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0);
    sb.push_back('{3'b010, pat(16'h0020)});
    step();
    @(negedge clk);
    chk("t6_gnt1", 32'(gnt),      32'h2);
    chk("t6_en1",  32'(mem_en),   32'h1);
    chk("t6_addr1", 32'(mem_addr), 32'h20);
    step();
    req[1] = 1'b0;
    set_req(0, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0);
    sb.push_back('{3'b001, pat(16'h0030)});
    @(negedge clk);
    chk("t6_gap_gnt", 32'(gnt),    32'h2);
    chk("t6_gap_en",  32'(mem_en), 32'h0);
    step();
    @(negedge clk);
    chk("t6_gnt0",  32'(gnt),      32'h1);
    chk("t6_en0",   32'(mem_en),   32'h1);
    chk("t6_addr0", 32'(mem_addr), 32'h30);
    step();
    req[0]  = 1'b0;
    lock[1] = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("t6_idle_gnt",  32'(gnt),  32'h0);
    chk("t6_idle_busy", 32'(busy), 32'h0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
